regbank_write_arbiter: RTL and testbench

REGBANK_WRITE_ARBITER -- requirements
Module: regbank_write_arbiter

---
 rtl/regbank_write_arbiter.sv | 137 +++++++++++++
 tb/tb_regbank_write_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter merging NREQ register-write requesters onto one registered write port,
// with a one-shot sweep that zeroes every register; write latency 1 cycle, clear holds off all grants.
module regbank_write_arbiter #(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic                     clr_start,
    output logic                     clr_busy,
    output logic                     clr_done,
    output logic                     write,
    output logic [ADDR_W-1:0]        dr,
    output logic [DATA_W-1:0]        wrData
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   dr_q, dr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                done_q, done_d;

    logic                arb_en;
    logic                found;
    logic [PTR_W-1:0]    gnt_idx;
    logic                hs;
    logic [ADDR_W-1:0]   gnt_addr;
    logic [DATA_W-1:0]   gnt_data;

    // Clear request takes the port in the same cycle it is seen, so no grant may issue then.
    assign arb_en = !reset && (state_q == IDLE) && !clr_start;

    always_comb begin
        int idx;
        idx     = 0;
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                gnt_idx = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (arb_en && found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign hs       = arb_en && found;
    assign gnt_addr = req_addr[gnt_idx*ADDR_W +: ADDR_W];
    assign gnt_data = req_data[gnt_idx*DATA_W +: DATA_W];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        write_d   = 1'b0;
        dr_d      = dr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (hs) begin
                    ptr_d = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
                    // Writes to r0 complete the handshake but never reach the bank.
                    if (!(ZERO_R0 && (gnt_addr == '0))) begin
                        write_d   = 1'b1;
                        dr_d      = gnt_addr;
                        wr_data_d = gnt_data;
                    end
                end
            end
            CLEAR: begin
                write_d   = 1'b1;
                dr_d      = cnt_q;
                wr_data_d = '0;
                cnt_d     = cnt_q + ADDR_W'(1);
                if (cnt_q == '1) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            write_q   <= 1'b0;
            dr_q      <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            write_q   <= write_d;
            dr_q      <= dr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
        end
    end

    // Strobes are masked by reset so a write staged just before reset never lands.
    assign write    = write_q && !reset;
    assign clr_done = done_q && !reset;
    assign clr_busy = (state_q == CLEAR) && !reset;
    assign dr       = dr_q;
    assign wrData   = wr_data_q;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed bench for regbank_write_arbiter; expected writes are queued by the stimulus and drained by a monitor.
module tb_regbank_write_arbiter;

    localparam int NREQ   = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic                    clk;
    logic                    reset;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*ADDR_W-1:0]  req_addr;
    logic [NREQ*DATA_W-1:0]  req_data;
    logic                    clr_start;
    logic                    clr_busy;
    logic                    clr_done;
    logic                    write;
    logic [ADDR_W-1:0]       dr;
    logic [DATA_W-1:0]       wrData;

    regbank_write_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ZERO_R0(1'b1)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .write(write), .dr(dr), .wrData(wrData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every bank write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [ADDR_W+DATA_W-1:0] e;
        if (write === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL wr_unexpected: got dr=%0d data=0x%0h, expected no write", dr, wrData);
            end else begin
                e = exp_q.pop_front();
                chk("wr_dr", 32'(dr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
                chk("wr_data", wrData, e[DATA_W-1:0]);
            end
        end
        if (clr_done === 1'b1) begin
            done_cnt++;
            chk("done_with_write", 32'(write), 32'd1);
            chk("done_addr", 32'(dr), 32'd31);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt;
        reset     = 1'b1;
        clr_start = 1'b0;
        req_valid = 4'hF;
        req_addr  = '0;
        req_data  = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, ADDR_W'(10 + i), 32'h1000 + 32'(i));
        repeat (3) next_cycle();

        // Reset state, with requesters already valid
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_write", 32'(write), 32'h0);
        chk("rst_dr", 32'(dr), 32'h0);
        chk("rst_wrdata", wrData, 32'h0);
        chk("rst_busy", 32'(clr_busy), 32'h0);
        chk("rst_done", 32'(clr_done), 32'h0);
        next_cycle();
        reset = 1'b0;

        // All valid: grants 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
            push(ADDR_W'(10 + (k % 4)), 32'h1000 + 32'(k % 4));
            next_cycle();
        end
        req_valid = 4'h0;

        // Only requester 2 valid (ptr=1)
        set_req(2, 5'd7, 32'hDEADBEEF);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("solo2_ready", 32'(req_ready), 32'h4);
        push(5'd7, 32'hDEADBEEF);
        next_cycle();
        req_valid = 4'h0;
        set_req(2, 5'd12, 32'h1002);
        next_cycle();
        req_valid = 4'hF;
        @(negedge clk);
        chk("ptr_after_2", 32'(req_ready), 32'h8);
        push(5'd13, 32'h1003);
        next_cycle();
        req_valid = 4'h0;

        // Write to r0 from requester 1 (ptr=0): accepted, dropped, ptr -> 2
        set_req(1, 5'd0, 32'h5555AAAA);
        req_valid = 4'b0010;
        @(negedge clk);
        chk("r0_ready", 32'(req_ready), 32'h2);
        next_cycle();
        req_valid = 4'h0;
        set_req(1, 5'd11, 32'h1001);
        @(negedge clk);
        chk("r0_no_write", 32'(write), 32'h0);
        next_cycle();
        req_valid = 4'b0110;
        @(negedge clk);
        chk("ptr_after_r0", 32'(req_ready), 32'h4);
        push(5'd12, 32'h1002);
        next_cycle();
        req_valid = 4'h0;

        // Reset in the cycle after a handshake (ptr=3 -> grant 0): write discarded
        req_valid = 4'b0001;
        @(negedge clk);
        chk("pre_rst_grant", 32'(req_ready), 32'h1);
        next_cycle();
        reset = 1'b1;
        req_valid = 4'h0;
        @(negedge clk);
        chk("rst_drops_write", 32'(write), 32'h0);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // Clear sweep with requesters 0 and 1 valid (ptr=0 after reset)
        req_valid = 4'b0011;
        clr_start = 1'b1;
        @(negedge clk);
        chk("clr_T_ready", 32'(req_ready), 32'h0);
        for (int i = 0; i < 32; i++) push(ADDR_W'(i), 32'h0);
        next_cycle();
        clr_start = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            chk("clr_ready", 32'(req_ready), 32'h0);
            chk("clr_busy", 32'(clr_busy), 32'h1);
            chk("clr_done_early", 32'(clr_done), 32'h0);
            next_cycle();
        end
        @(negedge clk);
        chk("clr_end_busy", 32'(clr_busy), 32'h0);
        chk("clr_end_done", 32'(clr_done), 32'h1);
        chk("clr_resume_grant", 32'(req_ready), 32'h1);
        push(5'd10, 32'h1000);
        next_cycle();
        @(negedge clk);
        chk("clr_resume_grant2", 32'(req_ready), 32'h2);
        push(5'd11, 32'h1001);
        next_cycle();
        req_valid = 4'h0;
        next_cycle();

        // clr_start re-pulsed at T+5 is ignored
        clr_start = 1'b1;
        for (int i = 0; i < 32; i++) push(ADDR_W'(i), 32'h0);
        next_cycle();
        for (int c = 1; c <= 32; c++) begin
            clr_start = (c == 5);
            @(negedge clk);
            chk("repulse_busy", 32'(clr_busy), 32'h1);
            chk("repulse_done_early", 32'(clr_done), 32'h0);
            next_cycle();
        end
        clr_start = 1'b0;
        @(negedge clk);
        chk("repulse_done", 32'(clr_done), 32'h1);
        next_cycle();
        @(negedge clk);
        chk("repulse_no_extend_busy", 32'(clr_busy), 32'h0);
        chk("repulse_no_extend_wr", 32'(write), 32'h0);
        next_cycle();

        // Reset at T+10 of a sweep aborts it
        dcnt = done_cnt;
        clr_start = 1'b1;
        for (int i = 0; i < 8; i++) push(ADDR_W'(i), 32'h0);
        next_cycle();
        clr_start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            chk("abort_busy", 32'(clr_busy), 32'h1);
            next_cycle();
        end
        reset = 1'b1;
        @(negedge clk);
        chk("abort_rst_write", 32'(write), 32'h0);
        chk("abort_rst_busy", 32'(clr_busy), 32'h0);
        next_cycle();
        reset = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            chk("abort_no_write", 32'(write), 32'h0);
            chk("abort_no_busy", 32'(clr_busy), 32'h0);
            next_cycle();
        end
        chk("abort_no_done", 32'(done_cnt), 32'(dcnt));
        req_valid = 4'hF;
        @(negedge clk);
        chk("abort_grant", 32'(req_ready), 32'h1);
        push(5'd10, 32'h1000);
        next_cycle();
        req_valid = 4'h0;
        repeat (3) next_cycle();

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
